// File: rtl/cc_pkg.sv
// Shared types and constants for the cc game controller: FSM states and the
// obstacle-row LFSR definition.
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam int         LFSR_TAP_A = 7;
  localparam int         LFSR_TAP_B = 5;
  localparam int         LFSR_TAP_C = 4;
  localparam int         LFSR_TAP_D = 3;

  // Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/cc_lfsr.sv
// 8-bit pseudo-random source for obstacle rows; seeds on reset and steps
// only when enabled so the sequence is tied to game ticks.
module cc_lfsr
  import cc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/cc_game_ctrl.sv
// Game sequencer for the cc player column: FSM, step prescaler, scrolling
// obstacle field, collision detection and scoring.
module cc_game_ctrl
  import cc_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int DEPTH      = 8,
  parameter int TICK_WIDTH = 7,
  parameter int GAP        = 4,
  parameter int WIN_SCORE  = 15
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ROWS-1:0]                      player,
  output logic                                 active,
  output logic                                 over,
  output logic                                 win,
  output logic [$clog2(WIN_SCORE+1)-1:0]       score,
  output logic [DEPTH*ROWS-1:0]                field
);

  localparam int GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int SCORE_W = $clog2(WIN_SCORE + 1);

  state_e                  state_q;
  logic                    start_q;
  logic                    active_q;
  logic                    over_q;
  logic                    win_q;
  logic [SCORE_W-1:0]      score_q;
  logic [DEPTH*ROWS-1:0]   field_q;
  logic [TICK_WIDTH-1:0]   presc_q;
  logic [GAP_W-1:0]        gap_q;

  logic                    start_rise;
  logic                    tick;
  logic                    hit;
  logic                    lfsr_en;
  logic [7:0]              lfsr_val;
  logic [ROWS-1:0]         ins_col;
  logic [DEPTH*ROWS-1:0]   field_d;
  logic [GAP_W-1:0]        gap_d;
  logic [SCORE_W-1:0]      score_d;

  assign start_rise = start & ~start_q;
  assign tick       = (presc_q == '0);
  assign hit        = |(field_q[ROWS-1:0] & player);
  assign lfsr_en    = (state_q == PLAY) && tick && !hit;

  cc_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .q     (lfsr_val)
  );

  // ROWS is a power of two, so the modulo selects the low log2(ROWS) bits.
  assign ins_col = (gap_q == '0) ? (ROWS'(1) << ({1'b0, lfsr_val} % 9'(ROWS)))
                                 : '0;

  for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_shift
    assign field_d[gi*ROWS +: ROWS] = field_q[(gi+1)*ROWS +: ROWS];
  end
  assign field_d[(DEPTH-1)*ROWS +: ROWS] = ins_col;

  assign gap_d   = (gap_q == GAP_W'(GAP - 1)) ? '0 : gap_q + 1'b1;
  assign score_d = score_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
      score_q  <= '0;
      field_q  <= '0;
      presc_q  <= '0;
      gap_q    <= '0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q  <= PLAY;
            active_q <= 1'b1;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
            score_q  <= '0;
            field_q  <= '0;
            presc_q  <= '0;
            gap_q    <= '0;
          end
        end
        PLAY: begin
          presc_q <= presc_q + 1'b1;
          // A collision wins over a coincident tick: nothing moves or scores.
          if (hit) begin
            state_q <= OVER;
            over_q  <= 1'b1;
            win_q   <= 1'b0;
          end else if (tick) begin
            field_q <= field_d;
            gap_q   <= gap_d;
            if (field_q[ROWS-1:0] != '0) begin
              score_q <= score_d;
              if (score_d == SCORE_W'(WIN_SCORE)) begin
                state_q <= OVER;
                over_q  <= 1'b1;
                win_q   <= 1'b1;
              end
            end
          end
        end
        OVER: begin
          if (start_rise) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
            score_q  <= '0;
            field_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign active = active_q;
  assign over   = over_q;
  assign win    = win_q;
  assign score  = score_q;
  assign field  = field_q;

endmodule

// File: tb/tb_cc_game_ctrl.sv
// Directed bench for cc_game_ctrl with ROWS=8, DEPTH=4, TICK_WIDTH=2, GAP=2,
// WIN_SCORE=3 (one tick every 4 cycles); expected fields computed by hand.
module tb_cc_game_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  player;
  logic        active;
  logic        over;
  logic        win;
  logic [1:0]  score;
  logic [31:0] field;

  int checks = 0;
  int errors = 0;

  cc_game_ctrl #(
    .ROWS       (8),
    .DEPTH      (4),
    .TICK_WIDTH (2),
    .GAP        (2),
    .WIN_SCORE  (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .player (player),
    .active (active),
    .over   (over),
    .win    (win),
    .score  (score),
    .field  (field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cycles;
    logic        rst;
    logic        st;
    logic [7:0]  pl;
    logic        e_act;
    logic        e_over;
    logic        e_win;
    logic [1:0]  e_score;
    logic [31:0] e_field;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic ea, input logic eo, input logic ew);
    $display("[%0t] %s: active=%0b over=%0b win=%0b score=%0d field=%08h",
             $time, name, active, over, win, score, field);
    cmp({name, ".active"}, 32'(active), 32'(ea));
    cmp({name, ".over"},   32'(over),   32'(eo));
    cmp({name, ".win"},    32'(win),    32'(ew));
  endtask

  task automatic check_all(input string name, input logic ea, input logic eo, input logic ew,
                           input logic [1:0] es, input logic [31:0] ef);
    check_flags(name, ea, eo, ew);
    cmp({name, ".score"}, 32'(score), 32'(es));
    cmp({name, ".field"}, field, ef);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    player = 8'h01;

    // Reset with start held, then a full winning game (rows 5, 5, 4 scored).
    vecs.push_back('{"reset1", 1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000});
    vecs.push_back('{"reset2", 1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000});
    vecs.push_back('{"idle",   2, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000});
    vecs.push_back('{"start",  1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000});
    vecs.push_back('{"tick0",  1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h2000_0000});
    vecs.push_back('{"hold0",  3, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h2000_0000});
    vecs.push_back('{"tick1",  1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0020_0000});
    vecs.push_back('{"tick2",  4, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h2000_2000});
    vecs.push_back('{"tick3",  4, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0020_0020});
    vecs.push_back('{"tick4",  4, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 32'h1000_2000});
    vecs.push_back('{"tick5",  4, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0010_0020});
    vecs.push_back('{"tick6",  4, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0800_1000});
    vecs.push_back('{"tick7",  4, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0008_0010});
    vecs.push_back('{"pre8",   3, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0008_0010});
    vecs.push_back('{"tick8",  1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 2'd3, 32'h4000_0800});
    vecs.push_back('{"frozen", 8, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 2'd3, 32'h4000_0800});

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      start  = vecs[i].st;
      player = vecs[i].pl;
      step(vecs[i].cycles);
      check_all(vecs[i].name, vecs[i].e_act, vecs[i].e_over, vecs[i].e_win,
                vecs[i].e_score, vecs[i].e_field);
    end

    // Restart from OVER; a held start must not produce a second event.
    start = 1'b1;
    step(1);
    check_flags("restart_idle", 1'b0, 1'b0, 1'b0);
    step(3);
    check_flags("start_held", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    check_all("replay", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000);

    // Reset mid-game.
    start = 1'b0;
    step(5);
    reset = 1'b1;
    step(1);
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000);

    // Collision: player moves onto row 5 before the obstacle reaches col 0.
    reset = 1'b0;
    player = 8'h01;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check_all("c_tick0", 1'b1, 1'b0, 1'b0, 2'd0, 32'h2000_0000);
    step(8);
    player = 8'h20;
    step(4);
    check_all("c_tick3", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0020_0020);
    step(1);
    check_all("c_hit", 1'b1, 1'b1, 1'b0, 2'd0, 32'h0020_0020);
    step(20);
    check_all("c_frozen", 1'b1, 1'b1, 1'b0, 2'd0, 32'h0020_0020);

    // Hit in the same cycle as tick 4: no shift, no score.
    reset = 1'b1;
    player = 8'h01;
    step(1);
    reset = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);
    check_all("s_pre", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0020_0020);
    player = 8'h20;
    step(1);
    check_all("s_hit_tick", 1'b1, 1'b1, 1'b0, 2'd0, 32'h0020_0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
